// File: rtl/stream_demux4_pkg.sv
// Shared constants and FSM state type for the 1:4 packet demultiplexer.
package stream_demux4_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;
endpackage

// File: rtl/stream_slice.sv
// One-entry output register slice: loads a beat, holds it stable until drained.
module stream_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // A load wins over a drain, so drain+load in one cycle keeps the slice full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
endmodule

// File: rtl/stream_demux4.sv
// Packet-aware 1:4 valid/ready demultiplexer with per-channel delivered-packet counters.
module stream_demux4
    import stream_demux4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_last,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_last,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*CNT_W-1:0]  pkt_cnt,
    output logic                     busy
);
    state_t             r_state;
    logic [SEL_W-1:0]   r_lock_sel;
    logic [SEL_W-1:0]   w_route;
    logic               w_accept;
    logic [NUM_CH-1:0]  w_load;

    // in_sel only matters on a packet's first beat; later beats follow the lock.
    assign w_route  = (r_state == LOCKED) ? r_lock_sel : in_sel;
    assign in_ready = ~out_valid[w_route] | out_ready[w_route];
    assign w_accept = in_valid & in_ready;
    assign busy     = (r_state == LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_lock_sel <= '0;
        end else if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (!in_last) begin
                        r_state    <= LOCKED;
                        r_lock_sel <= in_sel;
                    end
                end
                LOCKED: begin
                    if (in_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [CNT_W-1:0] r_cnt;

            assign w_load[gi] = w_accept & (w_route == SEL_W'(gi));

            stream_slice #(
                .DATA_W(DATA_W)
            ) u_slice (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (w_load[gi]),
                .i_data (in_data),
                .i_last (in_last),
                .i_ready(out_ready[gi]),
                .o_valid(out_valid[gi]),
                .o_data (out_data[gi*DATA_W +: DATA_W]),
                .o_last (out_last[gi])
            );

            // Counts packets as their last beat leaves the slice; wraps freely.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (out_valid[gi] && out_ready[gi] && out_last[gi]) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign pkt_cnt[gi*CNT_W +: CNT_W] = r_cnt;
        end
    endgenerate
endmodule

// File: tb/tb_stream_demux4.sv
// Self-checking bench for stream_demux4: directed vector table, corner sequences, random traffic vs model.
module tb_stream_demux4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic [1:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_last;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'hF;
    logic [31:0] pkt_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: what each output holds, packet lock, delivered counts.
    logic [3:0] m_valid = '0;
    logic [3:0] m_last = '0;
    logic [7:0] m_data [4] = '{default: 8'h00};
    logic [7:0] m_cnt  [4] = '{default: 8'h00};
    logic       m_inpkt = 1'b0;
    logic [1:0] m_ch = '0;
    bit         m_init = 1'b0;
    logic       smp_ready;

    stream_demux4 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
        .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .pkt_cnt(pkt_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive, check in_ready mid-cycle, advance model, check outputs.
    task automatic cycle(input logic rstn, input logic v, input logic [7:0] d,
                         input logic l, input logic [1:0] s, input logic [3:0] rdy);
        logic [1:0] dest;
        logic       exp_rdy;
        rst_n = rstn; in_valid = v; in_data = d; in_last = l; in_sel = s; out_ready = rdy;
        #3;
        dest      = m_inpkt ? m_ch : s;
        exp_rdy   = !m_valid[dest] || rdy[dest];
        smp_ready = in_ready;
        if (m_init) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        @(posedge clk);
        if (!rstn) begin
            m_valid = '0; m_last = '0; m_inpkt = 1'b0; m_ch = '0; m_init = 1'b1;
            for (int c = 0; c < 4; c++) begin m_data[c] = '0; m_cnt[c] = '0; end
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (m_valid[c] && rdy[c]) begin
                    if (m_last[c]) m_cnt[c] = m_cnt[c] + 8'd1;
                    m_valid[c] = 1'b0;
                end
            end
            if (v && exp_rdy) begin
                m_valid[dest] = 1'b1;
                m_data[dest]  = d;
                m_last[dest]  = l;
                if (!m_inpkt && !l) begin m_inpkt = 1'b1; m_ch = s; end
                else if (m_inpkt && l) m_inpkt = 1'b0;
            end
        end
        #1;
        if (m_init) begin
            chk("out_valid", {28'd0, out_valid}, {28'd0, m_valid});
            chk("out_last", {28'd0, out_last}, {28'd0, m_last});
            chk("out_data", out_data, {m_data[3], m_data[2], m_data[1], m_data[0]});
            chk("pkt_cnt", pkt_cnt, {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
            chk("busy", {31'd0, busy}, {31'd0, m_inpkt});
        end
    endtask

    typedef struct {
        logic       rstn;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic [1:0] s;
        logic [3:0] rdy;
        logic       e_rdy;
        logic [3:0] e_ov;
        logic       e_busy;
        logic [1:0] e_ch;
        logic [7:0] e_d;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [7:0] dch;
        // rstn v  d   l  s  rdy | in_ready out_valid busy ch data
        tbl[0]  = '{1'b0, 1'b1, 8'h00, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 2'd2, 4'hF, 1'b1, 4'h4, 1'b0, 2'd2, 8'hA5};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2, 8'hA5};
        tbl[5]  = '{1'b1, 1'b1, 8'h11, 1'b0, 2'd1, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'h11};
        tbl[6]  = '{1'b1, 1'b1, 8'h22, 1'b0, 2'd3, 4'hF, 1'b1, 4'h2, 1'b1, 2'd1, 8'h22};
        tbl[7]  = '{1'b1, 1'b1, 8'h33, 1'b1, 2'd3, 4'hF, 1'b1, 4'h2, 1'b0, 2'd1, 8'h33};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd3, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 8'hB1, 1'b0, 2'd0, 4'hE, 1'b1, 4'h1, 1'b1, 2'd0, 8'hB1};
        tbl[10] = '{1'b1, 1'b1, 8'hB2, 1'b1, 2'd0, 4'hE, 1'b0, 4'h1, 1'b1, 2'd0, 8'hB1};
        tbl[11] = '{1'b1, 1'b1, 8'hB2, 1'b1, 2'd0, 4'hE, 1'b0, 4'h1, 1'b1, 2'd0, 8'hB1};
        tbl[12] = '{1'b1, 1'b1, 8'hB2, 1'b1, 2'd0, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 8'hB2};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 8'hB2};
        tbl[14] = '{1'b1, 1'b1, 8'hC1, 1'b1, 2'd0, 4'hE, 1'b1, 4'h1, 1'b0, 2'd0, 8'hC1};
        tbl[15] = '{1'b1, 1'b1, 8'hD3, 1'b1, 2'd3, 4'hE, 1'b1, 4'h9, 1'b0, 2'd3, 8'hD3};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3, 8'hD3};

        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].rstn, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].s, tbl[i].rdy);
            if (i > 0) chk($sformatf("tbl%0d_ready", i), {31'd0, smp_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d_valid", i), {28'd0, out_valid}, {28'd0, tbl[i].e_ov});
            chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].e_busy});
            dch = out_data[tbl[i].e_ch*8 +: 8];
            chk($sformatf("tbl%0d_data", i), {24'd0, dch}, {24'd0, tbl[i].e_d});
            $display("vec %0d: sel=%0d data=%h in_ready=%b out_valid=%b busy=%b",
                     i, tbl[i].s, tbl[i].d, smp_ready, out_valid, busy);
        end
        chk("tbl_pkt_cnt", pkt_cnt, 32'h01010102);

        // Counter wrap: 256 back-to-back single-beat packets on channel 1.
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 8'($urandom), 1'b1, 2'd1, 4'hF);
        chk("wrap_cnt1_pre", {24'd0, pkt_cnt[15:8]}, 32'd255);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 2'd0, 4'hF);
        chk("wrap_cnt1", {24'd0, pkt_cnt[15:8]}, 32'd0);
        $display("wrap: pkt_cnt[1]=%0d", pkt_cnt[15:8]);

        // Mid-packet reset abandons the lock; next beat starts a fresh packet.
        cycle(1'b1, 1'b1, 8'h61, 1'b0, 2'd2, 4'hF);
        cycle(1'b1, 1'b1, 8'h62, 1'b0, 2'd0, 4'hF);
        chk("midpkt_busy", {31'd0, busy}, 32'd1);
        cycle(1'b0, 1'b1, 8'h63, 1'b0, 2'd2, 4'hF);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_cnt", pkt_cnt, 32'd0);
        cycle(1'b1, 1'b1, 8'h5A, 1'b1, 2'd3, 4'hF);
        chk("post_rst_valid", {28'd0, out_valid}, 32'h8);
        chk("post_rst_data", {24'd0, out_data[31:24]}, 32'h5A);
        $display("midpkt reset: busy=%b out_valid=%b", busy, out_valid);

        // Random traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 2) == 0, 2'($urandom), 4'($urandom) | 4'($urandom));
            if (i % 500 == 0)
                $display("rand %0d: out_valid=%b busy=%b pkt_cnt=%h", i, out_valid, busy, pkt_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- Packet-aware 1:4 stream demultiplexer with valid/ready handshake; the inverse of the team's 4:1 mux path.
- Routes each input packet, unsplit, to one of four output channels.
- The channel is chosen by in_sel on the first beat of the packet and locked until the last beat.
- Each output has a one-entry register slice; the block also keeps a per-channel delivered-packet counter.

Parameters:
- DATA_W, 8, width of one data beat.
- CNT_W, 8, width of each per-channel packet counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_data  input  DATA_W  input beat payload.
- in_last  input  1  marks final beat of packet.
- in_sel  input  2  destination channel; sampled only on the first beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts beat this cycle.
- out_data  output  4*DATA_W  channel i payload at bits [i*DATA_W +: DATA_W].
- out_last  output  4  per-channel last flag.
- out_valid  output  4  per-channel valid.
- out_ready  input  4  per-channel downstream ready.
- pkt_cnt  output  4*CNT_W  channel i delivered-packet count at [i*CNT_W +: CNT_W].
- busy  output  1  high while a packet is locked (state LOCKED).

Behaviour:
- Reset is synchronous on clk when rst_n=0. It forces:
  - state=IDLE, lock_sel=0.
  - out_valid=0, out_last=0, out_data=0.
  - pkt_cnt=0, busy=0.
  - Any buffered beats are discarded. Reset mid-packet abandons the packet; the next accepted beat after reset starts a new packet.
- Route channel r = in_sel when state=IDLE; r = lock_sel when state=LOCKED.
- in_ready = ~out_valid[r] | out_ready[r]. It is combinational and never depends on in_valid.
- Accept = in_valid & in_ready.
- States:
  - IDLE: on accept with in_last=0, latch lock_sel=in_sel and go to LOCKED. On accept with in_last=1 (single-beat packet), stay in IDLE.
  - LOCKED: in_sel is ignored. On accept with in_last=1, go to IDLE. Otherwise hold.
- Output slice i:
  - On accept with r=i, the slice loads in_data and in_last and sets out_valid[i]=1 next cycle. Latency is 1 cycle.
  - If out_valid[i]&out_ready[i] and there is no load, out_valid[i] clears next cycle.
  - Simultaneous drain and load on the same channel: the new beat replaces the old and out_valid stays 1. This gives full throughput of 1 beat/cycle.
  - out_data and out_last hold their value while out_valid=1 and out_ready=0. Payload is stable under backpressure.
- Slices other than r are unaffected by input traffic. They continue to drain independently, so several outputs can be valid at once.
- pkt_cnt[i] increments by 1 when out_valid[i]&out_ready[i]&out_last[i]. It wraps modulo 2^CNT_W (all-ones to 0) with no saturation.
- busy = (state==LOCKED), registered.
- in_valid=0 never changes state. out_ready of idle channels has no effect.
- Upstream is assumed to keep in_data, in_last and in_sel stable while in_valid=1 and in_ready=0. The block does not check this.

Decomposition:
- Package stream_demux4_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - The state typedef enum {IDLE, LOCKED}.
- One sub-module, stream_slice: a one-entry register slice with load, drain, data and last. Four instances are made by generate.
- The top holds the FSM, routing, in_ready mux and counters.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles with in_valid=1. Expect in_ready to follow r (1, because all slices are empty), but no load occurs: all out_valid=0, pkt_cnt=0, busy=0. After release, busy=0.
- Single-beat routing: send in_sel=2, in_data=8'hA5, in_last=1 with out_ready=4'hF. Expect next cycle out_valid=4'b0100, channel 2 data=A5, out_last[2]=1. Then pkt_cnt[2]=1 and busy stays 0.
- Lock and sel change: send a 3-beat packet 11,22,33 starting with in_sel=1, then drive in_sel=3 during beats 2-3. Expect all beats on channel 1, busy=1 until the last beat is accepted, and channel 3 never valid.
- Backpressure: with out_ready[0]=0, send 2 beats to channel 0. Expect beat 1 held stable and in_ready=0 on beat 2. Raise out_ready[0]=1: beat 2 loads in the same cycle beat 1 drains and out_valid[0] stays 1.
- Independent drain: fill channel 0 (blocked) and then send a single-beat packet to channel 3. Expect in_ready=1 for the channel 3 packet and both out_valid[0] and out_valid[3] =1.
- Counter wrap and mid-packet reset: deliver 256 single-beat packets on channel 1 and expect pkt_cnt[1]=0 after wrap. Then assert rst_n=0 mid-packet and expect IDLE with all slices empty.
